spike_row_packer: RTL and testbench

//  Feed side of the maxpool row unit. Collects per-pixel spike words (TIME_STEPS bits each) from the conv output stream.

---
 rtl/spike_row_packer.sv | 234 +++++++++++++++++++++++
 tb/tb_spike_row_packer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_row_packer.sv
// spike_row_packer
//   Feed side of the maxpool row unit. Pixel spike words from the conv output
//   stream are packed into one feature-map row. Each finished row is issued to
//   the pool unit as a one-cycle strobe. Two row buffers are used in turn, so
//   pixel intake continues while the other row is being pooled.
// Ports
//   s_clk, s_rst         clock; asynchronous active-high reset
//   code_valid           latch conv_in_ch / conv_img_size and abort the current frame
//   conv_in_ch           channels per frame
//   conv_img_size        pixels per row (also rows per channel)
//   s_pix_valid/ready    pixel handshake; ready depends only on registered state
//   s_pix_data           TIME_STEPS spike bits of one pixel
//   i_calculating_flag   pool unit busy
//   o_row_data_valid     one-cycle row strobe
//   o_row_data           packed row; pixel p sits at [(p+1)*T-1 : p*T]
//   o_frame_done         one-cycle pulse once the last row of a frame is released
//   o_cfg_err            latched configuration is illegal
module spike_row_packer #(
  parameter int IMG_WIDTH  = 32,
  parameter int TIME_STEPS = 4
) (
  input  logic                            s_clk,
  input  logic                            s_rst,
  input  logic                            code_valid,
  input  logic [15:0]                     conv_in_ch,
  input  logic [15:0]                     conv_img_size,
  input  logic                            s_pix_valid,
  output logic                            s_pix_ready,
  input  logic [TIME_STEPS-1:0]           s_pix_data,
  input  logic                            i_calculating_flag,
  output logic                            o_row_data_valid,
  output logic [IMG_WIDTH*TIME_STEPS-1:0] o_row_data,
  output logic                            o_frame_done,
  output logic                            o_cfg_err
);

  localparam int ROW_W = IMG_WIDTH * TIME_STEPS;
  localparam int PC_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [1:0]        guard_r, guard_nxt_s;
  logic              issue_s, release_s, frame_end_s;

  logic [15:0]       size_r;
  logic [31:0]       rows_total_r;
  logic              cfg_ok_r, cfg_err_r;
  logic [ROW_W-1:0]  buf_r [2];
  logic [1:0]        full_r;
  logic              fb_r, sb_r;
  logic [PC_W-1:0]   pc_r;
  logic [31:0]       rows_filled_r, rows_sent_r;
  logic              row_valid_r, frame_done_r;
  logic [ROW_W-1:0]  row_data_r;

  logic              legal_s, ready_s, accept_s, fill_done_s;
  logic [31:0]       rows_total_s;
  int                pix_lsb_s;
  logic [ROW_W-1:0]  row_merge_s;

  assign legal_s      = ~conv_img_size[0] & (conv_img_size >= 16'd4) &
                        (conv_img_size <= 16'(IMG_WIDTH)) & (conv_in_ch != 16'd0);
  assign rows_total_s = 32'(conv_img_size) * 32'(conv_in_ch);

  // Ready is decoded from registers only; a config cycle drops its pixel.
  assign ready_s     = cfg_ok_r & ~full_r[fb_r] & (rows_filled_r < rows_total_r);
  assign accept_s    = s_pix_valid & ready_s & ~code_valid;
  assign fill_done_s = accept_s & (32'(pc_r) == (32'(size_r) - 32'd1));
  assign pix_lsb_s   = int'(pc_r) * TIME_STEPS;

  // Row seen by the sender: includes the pixel being written this cycle so a
  // row completed now can strobe on the very next cycle.
  always_comb begin
    row_merge_s = buf_r[sb_r];
    if (accept_s && (fb_r == sb_r)) begin
      row_merge_s[pix_lsb_s +: TIME_STEPS] = s_pix_data;
    end else begin
      row_merge_s = buf_r[sb_r];
    end
  end

  // Sender FSM next state; config aborts any row in flight.
  always_comb begin
    state_nxt_s = state_r;
    guard_nxt_s = guard_r;
    issue_s     = 1'b0;
    release_s   = 1'b0;
    frame_end_s = 1'b0;
    if (code_valid) begin
      state_nxt_s = ST_IDLE;
      guard_nxt_s = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (full_r[sb_r] || (fill_done_s && (fb_r == sb_r))) begin
            state_nxt_s = ST_ISSUE;
            issue_s     = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          guard_nxt_s = 2'd2;
          state_nxt_s = ST_GUARD;
        end
        // The pool flag rises two cycles after the strobe, so it is not
        // trusted until the guard has run out.
        ST_GUARD: begin
          guard_nxt_s = guard_r - 2'd1;
          if (guard_r <= 2'd1) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_GUARD;
          end
        end
        ST_DRAIN: begin
          if (!i_calculating_flag) begin
            release_s   = 1'b1;
            frame_end_s = ((rows_sent_r + 32'd1) == rows_total_r);
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          guard_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // Sender FSM state register
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_r <= ST_IDLE;
      guard_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      guard_r <= guard_nxt_s;
    end
  end

  // Config, row buffers, counters and registered outputs
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      size_r        <= 16'd0;
      rows_total_r  <= 32'd0;
      cfg_ok_r      <= 1'b0;
      cfg_err_r     <= 1'b0;
      buf_r[0]      <= {ROW_W{1'b0}};
      buf_r[1]      <= {ROW_W{1'b0}};
      full_r        <= 2'b00;
      fb_r          <= 1'b0;
      sb_r          <= 1'b0;
      pc_r          <= {PC_W{1'b0}};
      rows_filled_r <= 32'd0;
      rows_sent_r   <= 32'd0;
      row_valid_r   <= 1'b0;
      frame_done_r  <= 1'b0;
      row_data_r    <= {ROW_W{1'b0}};
    end else if (code_valid) begin
      size_r        <= conv_img_size;
      rows_total_r  <= rows_total_s;
      cfg_ok_r      <= legal_s;
      cfg_err_r     <= ~legal_s;
      buf_r[0]      <= {ROW_W{1'b0}};
      buf_r[1]      <= {ROW_W{1'b0}};
      full_r        <= 2'b00;
      fb_r          <= 1'b0;
      sb_r          <= 1'b0;
      pc_r          <= {PC_W{1'b0}};
      rows_filled_r <= 32'd0;
      rows_sent_r   <= 32'd0;
      row_valid_r   <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      row_valid_r  <= issue_s;
      frame_done_r <= frame_end_s;
      if (issue_s) begin
        row_data_r <= row_merge_s;
      end
      // Release and fill-complete may hit different buffers in one cycle;
      // each buffer's flag is updated independently.
      for (int i = 0; i < 2; i++) begin
        if (release_s && (sb_r == 1'(i))) begin
          buf_r[i]  <= {ROW_W{1'b0}};
          full_r[i] <= 1'b0;
        end else if (accept_s && (fb_r == 1'(i))) begin
          buf_r[i][pix_lsb_s +: TIME_STEPS] <= s_pix_data;
          if (fill_done_s) begin
            full_r[i] <= 1'b1;
          end
        end
      end
      if (accept_s) begin
        if (fill_done_s) begin
          pc_r <= {PC_W{1'b0}};
          fb_r <= ~fb_r;
        end else begin
          pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      if (release_s) begin
        sb_r <= ~sb_r;
      end
      // Frame end rewinds both row counters so the next frame reuses the config.
      if (frame_end_s) begin
        rows_sent_r   <= 32'd0;
        rows_filled_r <= 32'd0;
      end else begin
        if (release_s) begin
          rows_sent_r <= rows_sent_r + 32'd1;
        end
        if (fill_done_s) begin
          rows_filled_r <= rows_filled_r + 32'd1;
        end
      end
    end
  end

  assign s_pix_ready      = ready_s;
  assign o_row_data_valid = row_valid_r;
  assign o_row_data       = row_data_r;
  assign o_frame_done     = frame_done_r;
  assign o_cfg_err        = cfg_err_r;

endmodule

// File: tb/tb_spike_row_packer.sv
// Directed bench for spike_row_packer: a config/legality vector table plus
// hand-written sequences for back-pressure, mid-row config and async reset.
module tb_spike_row_packer;

  localparam int RW = 128;

  logic          s_clk;
  logic          s_rst;
  logic          code_valid;
  logic [15:0]   conv_in_ch;
  logic [15:0]   conv_img_size;
  logic          s_pix_valid;
  logic          s_pix_ready;
  logic [3:0]    s_pix_data;
  logic          i_calculating_flag;
  logic          o_row_data_valid;
  logic [RW-1:0] o_row_data;
  logic          o_frame_done;
  logic          o_cfg_err;

  spike_row_packer #(.IMG_WIDTH(32), .TIME_STEPS(4)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .code_valid(code_valid),
    .conv_in_ch(conv_in_ch), .conv_img_size(conv_img_size),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready), .s_pix_data(s_pix_data),
    .i_calculating_flag(i_calculating_flag), .o_row_data_valid(o_row_data_valid),
    .o_row_data(o_row_data), .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  typedef struct {
    logic [15:0]   size;
    logic [15:0]   ch;
    logic          exp_err;
    logic          exp_ready;
    int            exp_strobes;
    logic [RW-1:0] exp_row;
  } vec_t;
  vec_t vecs [9];

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int pool_busy = 2;
  logic [RW-1:0] got_rows [$];
  int got_cyc [$];
  int acc_cyc [$];
  int fd_cnt = 0, fd_cyc = 0, acc_mon = 0, ready_viol = 0;
  bit chk_ready = 1'b0;
  int sz_cur = 4, tot_cur = 0;

  initial forever begin
    @(posedge s_clk);
    cyc_cnt++;
  end

  // Monitor: strobes, frame pulses, accepted pixels, ready drops.
  initial forever begin
    @(negedge s_clk);
    if (o_row_data_valid === 1'b1) begin
      got_rows.push_back(o_row_data);
      got_cyc.push_back(cyc_cnt);
    end
    if (o_frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc_cnt;
    end
    if (chk_ready && s_pix_valid && (s_pix_ready !== 1'b1) && (acc_mon < tot_cur) &&
        ((acc_mon / sz_cur) - got_rows.size() < 1)) ready_viol++;
    if (s_pix_valid && (s_pix_ready === 1'b1) && !code_valid && !s_rst) begin
      acc_mon++;
      acc_cyc.push_back(cyc_cnt);
    end
  end

  // Pool unit model: flag rises 2 cycles after a strobe for pool_busy cycles.
  initial begin
    i_calculating_flag = 1'b0;
    forever begin
      @(negedge s_clk);
      if (o_row_data_valid === 1'b1) begin
        @(posedge s_clk);
        @(posedge s_clk);
        #1 i_calculating_flag = 1'b1;
        repeat (pool_busy) @(posedge s_clk);
        #1 i_calculating_flag = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_at(input int i);
    if (i < got_rows.size()) return got_rows[i];
    return {RW{1'b0}};
  endfunction

  function automatic int gcyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1000;
  endfunction

  function automatic int acyc_at(input int i);
    if (i < acc_cyc.size()) return acc_cyc[i];
    return -1000;
  endfunction

  // Row r of a stream whose pixel k carries ((k%sz)+1+(k/sz)*shift) mod 16.
  function automatic logic [RW-1:0] exp_row(input int sz, input int r, input int shift);
    logic [RW-1:0] w;
    w = {RW{1'b0}};
    for (int i = 0; i < sz; i++) w[i*4 +: 4] = 4'(i + 1 + r * shift);
    return w;
  endfunction

  task automatic clear_mon();
    got_rows.delete();
    got_cyc.delete();
    acc_cyc.delete();
    fd_cnt = 0;
    acc_mon = 0;
    ready_viol = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [15:0] sz, input logic [15:0] ch);
    conv_img_size = sz;
    conv_in_ch = ch;
    code_valid = 1'b1;
    @(posedge s_clk);
    #1 code_valid = 1'b0;
  endtask

  task automatic send_pix(input int k0, input int n, input int sz, input int shift,
                          input int budget, output int sent);
    int p, c;
    p = 0;
    c = 0;
    while (p < n && c < budget) begin
      s_pix_valid = 1'b1;
      s_pix_data = 4'(((k0 + p) % sz) + 1 + ((k0 + p) / sz) * shift);
      @(negedge s_clk);
      if (s_pix_ready === 1'b1) p++;
      @(posedge s_clk);
      #1;
      c++;
    end
    s_pix_valid = 1'b0;
    sent = p;
  endtask

  initial begin
    int sent, bad, k, n0, gap;
    vecs[0] = '{16'd6,  16'd2, 1'b0, 1'b1, 1, 128'h654321};
    vecs[1] = '{16'd5,  16'd1, 1'b1, 1'b0, 0, 128'h0};
    vecs[2] = '{16'd34, 16'd1, 1'b1, 1'b0, 0, 128'h0};
    vecs[3] = '{16'd6,  16'd0, 1'b1, 1'b0, 0, 128'h0};
    vecs[4] = '{16'd4,  16'd1, 1'b0, 1'b1, 1, 128'h4321};
    vecs[5] = '{16'd2,  16'd1, 1'b1, 1'b0, 0, 128'h0};
    vecs[6] = '{16'd32, 16'd1, 1'b0, 1'b1, 1, 128'h0FEDCBA987654321_0FEDCBA987654321};
    vecs[7] = '{16'd33, 16'd3, 1'b1, 1'b0, 0, 128'h0};
    vecs[8] = '{16'd8,  16'd3, 1'b0, 1'b1, 1, 128'h87654321};

    s_rst = 1'b1;
    code_valid = 1'b0;
    conv_in_ch = 16'd0;
    conv_img_size = 16'd0;
    s_pix_valid = 1'b0;
    s_pix_data = 4'd0;
    repeat (3) @(posedge s_clk);
    #1 s_rst = 1'b0;
    @(negedge s_clk);
    chk("rst_strobe", 128'(o_row_data_valid), 128'd0);
    chk("rst_row", o_row_data, 128'd0);
    chk("rst_frame_done", 128'(o_frame_done), 128'd0);
    chk("rst_cfg_err", 128'(o_cfg_err), 128'd0);
    chk("rst_ready", 128'(s_pix_ready), 128'd0);
    @(posedge s_clk);
    #1;

    // Config legality table with one row of pixels per vector
    for (int v = 0; v < 9; v++) begin
      apply_cfg(vecs[v].size, vecs[v].ch);
      @(negedge s_clk);
      chk($sformatf("cfg%0d_err", v), 128'(o_cfg_err), 128'(vecs[v].exp_err));
      chk($sformatf("cfg%0d_ready", v), 128'(s_pix_ready), 128'(vecs[v].exp_ready));
      @(posedge s_clk);
      #1;
      clear_mon();
      send_pix(0, vecs[v].exp_err ? 4 : int'(vecs[v].size), int'(vecs[v].size), 0, 60, sent);
      wait_cyc(12);
      chk($sformatf("cfg%0d_accepted", v), 128'(acc_mon),
          128'(vecs[v].exp_err ? 0 : int'(vecs[v].size)));
      chk($sformatf("cfg%0d_strobes", v), 128'(got_rows.size()), 128'(vecs[v].exp_strobes));
      chk($sformatf("cfg%0d_row", v), row_at(0), vecs[v].exp_row);
    end

    // size=4, ch=1: four rows of 0x4321, frame_done after the last drain
    pool_busy = 2;
    apply_cfg(16'd4, 16'd1);
    clear_mon();
    send_pix(0, 16, 4, 0, 200, sent);
    chk("t1_sent", 128'(sent), 128'd16);
    k = 0;
    while (fd_cnt < 1 && k < 100) begin wait_cyc(1); k++; end
    wait_cyc(3);
    chk("t1_strobes", 128'(got_rows.size()), 128'd4);
    for (int r = 0; r < 4; r++) chk($sformatf("t1_row%0d", r), row_at(r), 128'h4321);
    chk("t1_frame_done_cnt", 128'(fd_cnt), 128'd1);
    chk("t1_latency", 128'(gcyc_at(0) - acyc_at(3)), 128'd1);
    chk("t1_fd_after_drain",
        128'((fd_cyc - gcyc_at(3) >= 4) && (fd_cyc - gcyc_at(3) <= 5)), 128'd1);

    // size=32, ch=2, continuous valid, pool busy 16 cycles per row
    pool_busy = 16;
    apply_cfg(16'd32, 16'd2);
    clear_mon();
    sz_cur = 32;
    tot_cur = 64 * 32;
    chk_ready = 1'b1;
    send_pix(0, 64 * 32, 32, 1, 6000, sent);
    chk_ready = 1'b0;
    k = 0;
    while (fd_cnt < 1 && k < 300) begin wait_cyc(1); k++; end
    wait_cyc(2);
    chk("t2_sent", 128'(sent), 128'd2048);
    chk("t2_strobes", 128'(got_rows.size()), 128'd64);
    bad = 0;
    for (int r = 0; r < 64; r++) if (row_at(r) !== exp_row(32, r, 1)) bad++;
    chk("t2_rows_in_order", 128'(bad), 128'd0);
    chk("t2_ready_drop_only_when_full", 128'(ready_viol), 128'd0);
    chk("t2_frame_done_cnt", 128'(fd_cnt), 128'd1);

    // Pool flag stuck high for 100 cycles
    pool_busy = 100;
    sz_cur = 4;
    apply_cfg(16'd4, 16'd4);
    clear_mon();
    send_pix(0, 8, 4, 0, 40, sent);
    wait_cyc(20);
    @(negedge s_clk);
    chk("t4_ready_both_full", 128'(s_pix_ready), 128'd0);
    @(posedge s_clk);
    #1;
    chk("t4_one_strobe", 128'(got_rows.size()), 128'd1);
    chk("t4_accepted", 128'(acc_mon), 128'd8);
    send_pix(8, 4, 4, 0, 300, sent);
    k = 0;
    while (got_rows.size() < 2 && k < 50) begin wait_cyc(1); k++; end
    gap = gcyc_at(1) - gcyc_at(0);
    chk("t4_gap_after_flag", 128'((gap >= 103) && (gap <= 104)), 128'd1);
    chk("t4_ready_after_release", 128'(acyc_at(8) - gcyc_at(0)), 128'd103);
    chk("t4_row1", row_at(1), 128'h4321);
    pool_busy = 2;
    k = 0;
    while (i_calculating_flag && k < 250) begin wait_cyc(1); k++; end
    wait_cyc(4);

    // code_valid at pc=3 with a pixel presented the same cycle
    apply_cfg(16'd4, 16'd1);
    clear_mon();
    send_pix(0, 3, 4, 0, 10, sent);
    s_pix_valid = 1'b1;
    s_pix_data = 4'hF;
    code_valid = 1'b1;
    @(posedge s_clk);
    #1;
    code_valid = 1'b0;
    s_pix_valid = 1'b0;
    send_pix(0, 4, 4, 0, 20, sent);
    wait_cyc(10);
    chk("t5_strobes", 128'(got_rows.size()), 128'd1);
    chk("t5_row", row_at(0), 128'h4321);

    // Asynchronous reset during GUARD
    apply_cfg(16'd4, 16'd1);
    clear_mon();
    send_pix(0, 4, 4, 0, 10, sent);
    k = 0;
    while (o_row_data_valid !== 1'b1 && k < 20) begin @(negedge s_clk); k++; end
    chk("t6_strobe_seen", 128'(o_row_data_valid), 128'd1);
    @(posedge s_clk);
    #2 s_rst = 1'b1;
    #1;
    chk("t6_rst_row", o_row_data, 128'd0);
    chk("t6_rst_ready", 128'(s_pix_ready), 128'd0);
    chk("t6_rst_strobe", 128'(o_row_data_valid), 128'd0);
    chk("t6_rst_err", 128'(o_cfg_err), 128'd0);
    @(posedge s_clk);
    #1 s_rst = 1'b0;
    n0 = got_rows.size();
    wait_cyc(3);
    chk("t6_no_strobe_after_rst", 128'(got_rows.size()), 128'(n0));
    apply_cfg(16'd4, 16'd1);
    clear_mon();
    send_pix(0, 4, 4, 0, 10, sent);
    wait_cyc(10);
    chk("t6_strobes", 128'(got_rows.size()), 128'd1);
    chk("t6_row", row_at(0), 128'h4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
